// File: rtl/alu.sv
// RV32I integer ALU for the execute stage (OP and OP-IMM instructions).
// Decodes funct3/funct7 locally and returns a 32-bit result with a
// ready/done handshake. Non-shift operations and zero-amount shifts finish
// in the cycle that `ready` is pulsed.
//
// Optional build macro: ALU_SERIAL_SHIFT_EN
//   undefined : shifts use a single-cycle barrel shifter; done is always 1.
//   defined   : shifts by N != 0 run one bit per clock and finish N clocks
//               after the ready edge; done=0 from the ready cycle until then.
//
// Ports:
//   clk     rising-edge clock
//   rst     asynchronous reset, active-low
//   in1     operand 1 (rs1)
//   in2     operand 2 (rs2 or sign-extended immediate)
//   is_imm  1 = OP-IMM encoding, 0 = OP encoding
//   funct3  instruction funct3
//   funct7  instruction funct7 (imm[11:5] for OP-IMM shifts)
//   ready   one-cycle start pulse for a new operation
//   out     result
//   done    result on `out` is valid
module alu #(
    parameter int unsigned XLEN = 32
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [XLEN-1:0] in1,
    input  logic [XLEN-1:0] in2,
    input  logic            is_imm,
    input  logic [2:0]      funct3,
    input  logic [6:0]      funct7,
    input  logic            ready,
    output logic [XLEN-1:0] out,
    output logic            done
);

    localparam int unsigned SHAMT_W = 5;

    localparam logic [2:0] F3_ADD  = 3'b000;
    localparam logic [2:0] F3_SLL  = 3'b001;
    localparam logic [2:0] F3_SLT  = 3'b010;
    localparam logic [2:0] F3_SLTU = 3'b011;
    localparam logic [2:0] F3_XOR  = 3'b100;
    localparam logic [2:0] F3_SR   = 3'b101;
    localparam logic [2:0] F3_OR   = 3'b110;
    localparam logic [2:0] F3_AND  = 3'b111;

    // Only funct7[5] selects anything (SUB / SRA); the rest is ignored.
    logic unused_funct7;
    assign unused_funct7 = ^{funct7[6], funct7[4:0]};

    logic [SHAMT_W-1:0] shamt_c;
    logic               is_shift_c;
    logic               sub_c;
    logic [XLEN-1:0]    shl_c;
    logic [XLEN-1:0]    shr_c;
    logic [XLEN-1:0]    comb_res_c;

    assign shamt_c    = in2[SHAMT_W-1:0];
    assign is_shift_c = (funct3 == F3_SLL) || (funct3 == F3_SR);
    // ADDI has no SUB form; funct7[5] there is just an immediate bit.
    assign sub_c      = !is_imm && funct7[5];

`ifdef ALU_SERIAL_SHIFT_EN
    // Combinational shift path only serves zero-amount shifts.
    assign shl_c = in1;
    assign shr_c = in1;
`else
    assign shl_c = in1 << shamt_c;
    assign shr_c = funct7[5] ? XLEN'($signed(in1) >>> shamt_c) : (in1 >> shamt_c);
`endif

    // Single-cycle result for every operation.
    always_comb begin
        comb_res_c = '0;
        case (funct3)
            F3_ADD:  comb_res_c = sub_c ? (in1 - in2) : (in1 + in2);
            F3_SLL:  comb_res_c = shl_c;
            F3_SLT:  comb_res_c = XLEN'($signed(in1) < $signed(in2));
            F3_SLTU: comb_res_c = XLEN'(in1 < in2);
            F3_XOR:  comb_res_c = in1 ^ in2;
            F3_SR:   comb_res_c = shr_c;
            F3_OR:   comb_res_c = in1 | in2;
            F3_AND:  comb_res_c = in1 & in2;
            default: comb_res_c = '0;
        endcase
    end

`ifdef ALU_SERIAL_SHIFT_EN
    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } state_e;

    state_e             state_q;
    logic [XLEN-1:0]    shreg_q;
    logic [SHAMT_W-1:0] cnt_q;
    logic               sel_q;
    logic               left_q;
    logic               arith_q;
    logic               start_c;

    // Gated by rst so done reads 1 throughout reset.
    assign start_c = rst && (state_q == IDLE) && ready && is_shift_c
                     && (shamt_c != '0);

    // Iterative shifter: load on start, one bit per clock until count expires.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
            shreg_q <= '0;
            cnt_q   <= '0;
            sel_q   <= 1'b0;
            left_q  <= 1'b0;
            arith_q <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (start_c) begin
                        state_q <= BUSY;
                        shreg_q <= in1;
                        cnt_q   <= shamt_c;
                        sel_q   <= 1'b1;
                        left_q  <= (funct3 == F3_SLL);
                        arith_q <= (funct3 == F3_SR) && funct7[5];
                    end else if (ready) begin
                        sel_q <= 1'b0;
                    end
                end
                BUSY: begin
                    // Arithmetic right shift re-injects the original sign bit.
                    shreg_q <= left_q ? {shreg_q[XLEN-2:0], 1'b0}
                                      : {arith_q & shreg_q[XLEN-1], shreg_q[XLEN-1:1]};
                    cnt_q   <= cnt_q - SHAMT_W'(1);
                    if (cnt_q == SHAMT_W'(1)) begin
                        state_q <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign done = (state_q == IDLE) && !start_c;
    // A new ready in IDLE always shows the combinational path in its own cycle.
    assign out  = (sel_q && !(ready && (state_q == IDLE))) ? shreg_q : comb_res_c;
`else
    logic unused_clk_rst;
    assign unused_clk_rst = clk ^ rst ^ ready ^ is_shift_c;

    assign done = 1'b1;
    assign out  = comb_res_c;
`endif

endmodule

// File: tb/tb_alu.sv
// Self-checking bench for alu: directed cases plus randomized operations
// checked against an arithmetic reference model. Shift latency is modelled
// when built with ALU_SERIAL_SHIFT_EN.
module tb_alu;

    logic        clk;
    logic        rst;
    logic [31:0] in1;
    logic [31:0] in2;
    logic        is_imm;
    logic [2:0]  funct3;
    logic [6:0]  funct7;
    logic        ready;
    logic [31:0] out;
    logic        done;

    int checks = 0;
    int errors = 0;

    alu #(.XLEN(32)) dut (
        .clk    (clk),
        .rst    (rst),
        .in1    (in1),
        .in2    (in2),
        .is_imm (is_imm),
        .funct3 (funct3),
        .funct7 (funct7),
        .ready  (ready),
        .out    (out),
        .done   (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%08h exp=%08h", tag, got, exp);
        end
    endtask

    // Reference result straight from the RV32I operation table.
    function automatic logic [31:0] ref_alu(input logic [31:0] a, input logic [31:0] b,
                                            input logic imm, input logic [2:0] f3,
                                            input logic [6:0] f7);
        int unsigned sh;
        logic [31:0] r;
        sh = b % 32;
        case (f3)
            3'd0: r = (!imm && f7[5]) ? a - b : a + b;
            3'd1: r = a << sh;
            3'd2: r = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
            3'd3: r = (a < b) ? 32'd1 : 32'd0;
            3'd4: r = a ^ b;
            3'd5: r = f7[5] ? 32'($signed(a) >>> sh) : a >> sh;
            3'd6: r = a | b;
            default: r = a & b;
        endcase
        return r;
    endfunction

    function automatic int latency(input logic [31:0] b, input logic [2:0] f3);
        int n;
        n = 0;
`ifdef ALU_SERIAL_SHIFT_EN
        if (f3 == 3'd1 || f3 == 3'd5) n = b % 32;
`endif
        return n;
    endfunction

    // Issue one op with a ready pulse, follow it to done, then confirm it holds.
    task automatic run_op(input string tag, input logic [31:0] a, input logic [31:0] b,
                          input logic imm, input logic [2:0] f3, input logic [6:0] f7,
                          input logic [31:0] exp, input logic poke);
        int n;
        n = latency(b, f3);
        @(negedge clk);
        in1 = a; in2 = b; is_imm = imm; funct3 = f3; funct7 = f7; ready = 1'b1;
        #1;
        if (n == 0) begin
            check({tag, ".out0"}, out, exp);
            check({tag, ".done0"}, 32'(done), 32'd1);
        end else begin
            check({tag, ".busy0"}, 32'(done), 32'd0);
        end
        @(posedge clk);
        #1 ready = 1'b0;
        for (int i = 1; i <= n; i++) begin
            if (poke && i == 2) ready = 1'b1;
            @(posedge clk);
            #1 ready = 1'b0;
            if (i == n - 1) check({tag, ".busyN"}, 32'(done), 32'd0);
            if (i == n) begin
                check({tag, ".doneN"}, 32'(done), 32'd1);
                check({tag, ".outN"}, out, exp);
            end
        end
        @(negedge clk);
        check({tag, ".hold"}, out, exp);
        check({tag, ".holddone"}, 32'(done), 32'd1);
    endtask

    initial begin
        rst = 1'b0; ready = 1'b0; in1 = '0; in2 = '0;
        is_imm = 1'b0; funct3 = '0; funct7 = '0;
        #12;
        check("rst.done", 32'(done), 32'd1);
        check("rst.out", out, 32'd0);
        @(negedge clk);
        rst = 1'b1;

        // Directed cases
        run_op("sub",   32'd5, 32'd7, 1'b0, 3'd0, 7'h20, 32'hFFFF_FFFE, 1'b0);
        run_op("addi",  32'd5, 32'd7, 1'b1, 3'd0, 7'h20, 32'd12, 1'b0);
        run_op("slt",   32'hFFFF_FFFF, 32'd1, 1'b0, 3'd2, 7'h00, 32'd1, 1'b0);
        run_op("sltu",  32'hFFFF_FFFF, 32'd1, 1'b0, 3'd3, 7'h00, 32'd0, 1'b0);
        run_op("sra",   32'h8000_0000, 32'd4, 1'b0, 3'd5, 7'h20, 32'hF800_0000, 1'b0);
        run_op("srl",   32'h8000_0000, 32'd4, 1'b0, 3'd5, 7'h00, 32'h0800_0000, 1'b0);
        run_op("sra24", 32'h8000_0000, 32'h24, 1'b0, 3'd5, 7'h20, 32'hF800_0000, 1'b0);
        run_op("srl24", 32'h8000_0000, 32'h24, 1'b0, 3'd5, 7'h00, 32'h0800_0000, 1'b0);
        run_op("xor",   32'hF0F0_F0F0, 32'h0FF0_0FF0, 1'b0, 3'd4, 7'h00, 32'hFF00_FF00, 1'b0);
        run_op("or",    32'hF0F0_F0F0, 32'h0FF0_0FF0, 1'b0, 3'd6, 7'h00, 32'hFFF0_FFF0, 1'b0);
        run_op("and",   32'hF0F0_F0F0, 32'h0FF0_0FF0, 1'b0, 3'd7, 7'h00, 32'h00F0_00F0, 1'b0);
        run_op("sll31", 32'd1, 32'd31, 1'b0, 3'd1, 7'h00, 32'h8000_0000, 1'b1);
        run_op("sra0",  32'h8000_0001, 32'd32, 1'b0, 3'd5, 7'h20, 32'h8000_0001, 1'b0);
        run_op("addwrap", 32'hFFFF_FFFF, 32'd2, 1'b0, 3'd0, 7'h01, 32'd1, 1'b0);

        // Randomized operations against the reference model
        for (int k = 0; k < 150; k++) begin
            logic [31:0] a, b;
            logic [2:0]  f3;
            logic [6:0]  f7;
            logic        imm;
            a   = $urandom;
            b   = ($urandom_range(0, 1) == 0) ? 32'($urandom_range(0, 40)) : 32'($urandom);
            f3  = 3'($urandom_range(0, 7));
            f7  = 7'($urandom);
            imm = 1'($urandom);
            run_op($sformatf("rnd%0d", k), a, b, imm, f3, f7, ref_alu(a, b, imm, f3, f7), 1'b0);
        end

        // Asynchronous reset in the middle of a (possibly serial) shift
        @(negedge clk);
        in1 = 32'd1; in2 = 32'd31; is_imm = 1'b0; funct3 = 3'd1; funct7 = 7'h00; ready = 1'b1;
        @(posedge clk);
        #1 ready = 1'b0;
        repeat (5) @(posedge clk);
        #3 rst = 1'b0;
        #1;
        check("arst.done", 32'(done), 32'd1);
`ifndef ALU_SERIAL_SHIFT_EN
        check("arst.out", out, 32'h8000_0000);
`endif
        @(negedge clk);
        rst = 1'b1;
        run_op("postrst", 32'd2, 32'd3, 1'b0, 3'd0, 7'h00, 32'd5, 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/alu.md
Name: alu

Overview:
- RV32I integer ALU used by the CPU execute stage for OP (register-register) and OP-IMM (register-immediate) instructions.
- Decodes funct3/funct7 itself and produces a 32-bit result with a start/done handshake.
- Execute stage pulses `ready` for one cycle when a new instruction enters EX, then holds operands and control stable until `done` is seen.

Parameters:
- XLEN, 32, datapath width; only 32 is supported.

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  asynchronous reset, active-low (0 = reset)
- in1  input  32  operand 1 (rs1 value)
- in2  input  32  operand 2 (rs2 value, or sign-extended I-immediate)
- is_imm  input  1  1 = OP-IMM encoding, 0 = OP encoding
- funct3  input  3  instruction funct3
- funct7  input  7  instruction funct7 (for OP-IMM shifts, imm[11:5])
- ready  input  1  one-cycle start pulse for a new operation
- out  output  32  result
- done  output  1  result on `out` is valid

Behaviour:
- Operation by funct3:
  - 000: ADD; SUB when is_imm=0 and funct7[5]=1 (ADDI never subtracts)
  - 001: SLL
  - 010: SLT (signed), result 0/1
  - 011: SLTU (unsigned), result 0/1
  - 100: XOR
  - 101: SRL; SRA when funct7[5]=1
  - 110: OR
  - 111: AND
- Arithmetic rules:
  - Shift amount = in2[4:0]; in2[31:5] ignored.
  - Add/sub wrap modulo 2^32; no overflow flag.
  - All other funct7 bits ignored (no M extension).
- Non-shift ops, and shifts with amount 0: purely combinational.
  - `out` valid and `done`=1 in the same cycle as `ready`.
  - Zero additional latency.
- Inputs are held stable by the caller between `ready` and `done`. `out` must stay valid while done=1 and inputs are unchanged, until the next `ready`.
- Idle state: done=1.
  - `ready` is ignored while busy (multi-cycle mode only).
- Reset (rst=0, asynchronous):
  - busy cleared, internal shift register and result-select flag cleared.
  - done=1; `out` shows the combinational result of the current inputs.
  - Any in-flight operation is aborted.
- Shift implementation without the optional feature: single-cycle 32-bit barrel shifter; the block never enters a busy state.

Optional Feature:
- Macro ALU_SERIAL_SHIFT_EN.
- Defined: SLL/SRL/SRA with nonzero amount N use an iterative one-bit-per-cycle shifter.
  - On `ready`, load in1 into the shift register and enter BUSY.
  - done=0 from the `ready` cycle through the busy cycles; one bit is shifted per clock.
  - done returns to 1 exactly N clocks after the `ready` edge.
  - `out` then selects the shift register and holds until the next `ready`.
  - SRA fills with the original bit 31; SRL and SLL fill with 0.
  - A non-shift `ready` clears the shift-register select and returns `out` to the combinational path.
  - States: IDLE -> BUSY (ready & shift & N≠0) -> IDLE (count reaches 0).
- Undefined: barrel shifter; all ops single-cycle as above.

Test Plan:
- in1=5, in2=7, funct3=000, is_imm=0, funct7=0x20, ready pulse -> out=0xFFFFFFFE, done=1 in the ready cycle; same with is_imm=1 -> out=12.
- in1=0xFFFFFFFF, in2=1: funct3=010 -> out=1; funct3=011 -> out=0.
- in1=0x80000000, in2=4:
  - funct3=101, funct7=0x20 -> out=0xF8000000
  - funct7=0 -> out=0x08000000
  - in2=0x24 (amount 4) -> same results
- in1=0xF0F0F0F0, in2=0x0FF00FF0: XOR -> 0xFF00FF00, OR -> 0xFFF0FFF0, AND -> 0x00F000F0.
- Serial build: SLL in1=1, in2=31, ready -> done low for 31 cycles, then done=1, out=0x80000000; a second ready while busy is ignored.
- Drive rst=0 mid serial shift -> done=1 immediately (asynchronously); after release, an ADD of 2+3 -> out=5 in the ready cycle.
